window5_feeder: RTL and testbench



---
 rtl/haze_pkg.sv | 27 ++
 rtl/raster_counter.sv | 88 ++++++++
 rtl/window5_feeder.sv | 102 ++++++++++
 tb/tb_window5_feeder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal pipeline: pixel width, default raster
// geometry and the five-tap window record handed to the min/max comparator.
package haze_pkg;

  localparam int DATA_W         = 10;
  localparam int LINE_WIDTH_DEF = 640;
  localparam int NUM_LINES_DEF  = 480;
  localparam int COL_W_DEF      = 10;
  localparam int ROW_W_DEF      = 9;
  localparam int WIN_TAPS       = 5;

  // tap1 is the oldest sample, tap5 the newest; col is the column of tap1.
  typedef struct packed {
    logic [DATA_W-1:0]    tap1;
    logic [DATA_W-1:0]    tap2;
    logic [DATA_W-1:0]    tap3;
    logic [DATA_W-1:0]    tap4;
    logic [DATA_W-1:0]    tap5;
    logic [COL_W_DEF-1:0] col;
    logic [ROW_W_DEF-1:0] row;
  } window_t;

  function automatic logic [2:0] fill_step(input logic [2:0] fill);
    return (fill >= 3'(WIN_TAPS)) ? 3'(WIN_TAPS) : fill + 3'd1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row tracker for an incoming raster. Classifies each valid beat as taken
// or dropped and flags line end, frame end, frame restart and misplaced sof.
module raster_counter #(
  parameter int LINE_WIDTH = haze_pkg::LINE_WIDTH_DEF,
  parameter int NUM_LINES  = haze_pkg::NUM_LINES_DEF,
  parameter int COL_W      = haze_pkg::COL_W_DEF,
  parameter int ROW_W      = haze_pkg::ROW_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic             sof,
  output logic             take,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             line_end,
  output logic             frame_end,
  output logic             restart,
  output logic             in_frame,
  output logic             sof_err
);
  import haze_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_LINES - 1);

  // col_q/row_q hold the position the next accepted pixel will occupy.
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             in_frame_d;
  logic             sof_err_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      in_frame <= 1'b0;
      sof_err  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      in_frame <= in_frame_d;
      sof_err  <= sof_err_d;
    end
  end

  always_comb begin
    take       = 1'b0;
    restart    = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    pix_col    = col_q;
    pix_row    = row_q;
    col_d      = col_q;
    row_d      = row_q;
    in_frame_d = in_frame;
    sof_err_d  = sof_err;
    if (pix_valid && sof) begin
      // sof always wins: the beat becomes column 0 of a fresh frame.
      take       = 1'b1;
      restart    = 1'b1;
      pix_col    = '0;
      pix_row    = '0;
      col_d      = COL_W'(1);
      row_d      = '0;
      in_frame_d = 1'b1;
      if (in_frame && !(col_q == '0 && row_q == '0)) begin
        sof_err_d = 1'b1;
      end
    end else if (pix_valid && in_frame) begin
      take = 1'b1;
      if (col_q == LAST_COL) begin
        line_end = 1'b1;
        col_d    = '0;
        if (row_q == LAST_ROW) begin
          frame_end  = 1'b1;
          row_d      = '0;
          in_frame_d = 1'b0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/window5_feeder.sv
// Builds in-line five-sample windows from a raster stream and strobes each
// complete window to the 5-input min/max comparator for one cycle.
module window5_feeder #(
  parameter int DATA_W     = haze_pkg::DATA_W,
  parameter int LINE_WIDTH = haze_pkg::LINE_WIDTH_DEF,
  parameter int NUM_LINES  = haze_pkg::NUM_LINES_DEF,
  parameter int COL_W      = haze_pkg::COL_W_DEF,
  parameter int ROW_W      = haze_pkg::ROW_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2,
  output logic [DATA_W-1:0] tap3,
  output logic [DATA_W-1:0] tap4,
  output logic [DATA_W-1:0] tap5,
  output logic              Enable,
  output logic [COL_W-1:0]  win_col,
  output logic [ROW_W-1:0]  win_row,
  output logic              frame_done,
  output logic              sof_err
);
  import haze_pkg::*;

  // Handshake: pix_valid is a pure qualifier with no ready; every rising edge with
  // pix_valid high consumes pix_in. Enable is a one-cycle strobe with no ready
  // either; taps, win_col and win_row are only meaningful while it is high.

  logic             take;
  logic             restart;
  logic             line_end;
  logic             frame_end;
  logic             in_frame;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic [2:0]       fill_q;
  logic             win_ok;

  raster_counter #(
    .LINE_WIDTH(LINE_WIDTH),
    .NUM_LINES (NUM_LINES),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_raster (
    .clock    (clock),
    .reset    (reset),
    .pix_valid(pix_valid),
    .sof      (sof),
    .take     (take),
    .pix_col  (pix_col),
    .pix_row  (pix_row),
    .line_end (line_end),
    .frame_end(frame_end),
    .restart  (restart),
    .in_frame (in_frame),
    .sof_err  (sof_err)
  );

  // Four in-line samples already held plus this one make a full window; fill is
  // cleared at each line end so windows never straddle lines.
  assign win_ok = take && !restart && (fill_q >= 3'(WIN_TAPS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tap1       <= '0;
      tap2       <= '0;
      tap3       <= '0;
      tap4       <= '0;
      tap5       <= '0;
      fill_q     <= '0;
      Enable     <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      Enable     <= win_ok;
      frame_done <= frame_end;
      if (take) begin
        tap1 <= tap2;
        tap2 <= tap3;
        tap3 <= tap4;
        tap4 <= tap5;
        tap5 <= pix_in;
        if (restart) begin
          fill_q <= 3'd1;
        end else if (line_end) begin
          fill_q <= '0;
        end else begin
          fill_q <= fill_step(fill_q);
        end
      end
      if (win_ok) begin
        win_col <= pix_col - COL_W'(WIN_TAPS - 1);
        win_row <= pix_row;
      end
    end
  end

endmodule

// File: tb/tb_window5_feeder.sv
// Directed bench for window5_feeder on an 8x2 raster: expected windows queued
// by hand and matched against every Enable strobe.
module tb_window5_feeder;

  localparam int DW = 10;
  localparam int LW = 8;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam int RW = 2;
  localparam int W  = 5 * DW + CW + RW + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic [DW-1:0] tap1, tap2, tap3, tap4, tap5;
  logic          Enable;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          frame_done;
  logic          sof_err;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int fd_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_w;

  window5_feeder #(
    .DATA_W(DW), .LINE_WIDTH(LW), .NUM_LINES(NL), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap4(tap4), .tap5(tap5),
    .Enable(Enable), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  assign obs_w = {tap1, tap2, tap3, tap4, tap5, win_col, win_row, frame_done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // window starting at sample value b: b..b+4
  function automatic logic [W-1:0] win_val(input int b, input int c, input int r, input int f);
    return {DW'(b), DW'(b + 1), DW'(b + 2), DW'(b + 3), DW'(b + 4), CW'(c), RW'(r), 1'(f)};
  endfunction

  task automatic exp_win(input int b, input int c, input int r, input int f);
    exp_q.push_back(win_val(b, c, r, f));
  endtask

  // driver tasks: each call occupies exactly one cycle, returning #1 after the edge
  task automatic px(input int d, input bit s);
    pix_in    = DW'(d);
    sof       = s;
    pix_valid = 1'b1;
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && Enable) begin
      en_cnt++;
      if (exp_q.size() == 0) chk("win_extra", 64'(obs_w), 64'h0);
      else chk("win", 64'(obs_w), 64'(exp_q.pop_front()));
    end
    if (!reset && frame_done) begin
      fd_cnt++;
      chk("fd_with_en", 64'(Enable), 64'h1);
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_taps", 64'({tap1, tap2, tap3, tap4, tap5}), 64'h0);
    chk("rst_en", 64'(Enable), 64'h0);
    chk("rst_col", 64'(win_col), 64'h0);
    chk("rst_row", 64'(win_row), 64'h0);
    chk("rst_fd", 64'(frame_done), 64'h0);
    chk("rst_err", 64'(sof_err), 64'h0);
    reset = 1'b0;
    idle(1);

    // line 0, back to back
    exp_win(1, 0, 0, 0); exp_win(2, 1, 0, 0); exp_win(3, 2, 0, 0); exp_win(4, 3, 0, 0);
    for (int d = 1; d <= 8; d++) px(d, d == 1);
    idle(2);
    chk("l0_q", 64'(exp_q.size()), 64'h0);
    chk("l0_en", 64'(en_cnt), 64'd4);

    // line 1, ends the frame
    exp_win(11, 0, 1, 0); exp_win(12, 1, 1, 0); exp_win(13, 2, 1, 0); exp_win(14, 3, 1, 1);
    for (int d = 11; d <= 18; d++) px(d, 1'b0);
    idle(2);
    chk("l1_q", 64'(exp_q.size()), 64'h0);
    chk("l1_en", 64'(en_cnt), 64'd8);
    chk("l1_fd", 64'(fd_cnt), 64'd1);

    // pixels outside a frame are dropped
    for (int i = 0; i < 3; i++) px(90 + i, 1'b0);
    idle(1);
    chk("drop_taps", 64'({tap1, tap2, tap3, tap4, tap5}), 64'(win_val(14, 0, 0, 0) >> (CW + RW + 1)));
    chk("drop_col", 64'(win_col), 64'd3);
    chk("drop_row", 64'(win_row), 64'd1);
    chk("drop_en", 64'(en_cnt), 64'd8);

    // new frame, pix_valid toggling
    exp_win(31, 0, 0, 0); exp_win(32, 1, 0, 0); exp_win(33, 2, 0, 0); exp_win(34, 3, 0, 0);
    for (int i = 0; i < 8; i++) begin
      px(31 + i, i == 0);
      chk("tog_en", 64'(Enable), 64'(i >= 4));
      idle(1);
      chk("tog_idle", 64'(Enable), 64'h0);
    end
    exp_win(51, 0, 1, 0); exp_win(52, 1, 1, 0); exp_win(53, 2, 1, 0); exp_win(54, 3, 1, 1);
    for (int d = 51; d <= 58; d++) px(d, 1'b0);
    idle(2);
    chk("tog_q", 64'(exp_q.size()), 64'h0);
    chk("tog_fd", 64'(fd_cnt), 64'd2);

    // sof at col 6 abandons the frame
    exp_win(41, 0, 0, 0); exp_win(42, 1, 0, 0);
    for (int d = 41; d <= 46; d++) px(d, d == 41);
    chk("err_clear", 64'(sof_err), 64'h0);
    exp_win(61, 0, 0, 0); exp_win(62, 1, 0, 0); exp_win(63, 2, 0, 0); exp_win(64, 3, 0, 0);
    px(61, 1'b1);
    chk("err_set", 64'(sof_err), 64'h1);
    for (int d = 62; d <= 68; d++) px(d, 1'b0);
    idle(2);
    chk("abandon_fd", 64'(fd_cnt), 64'd2);
    exp_win(71, 0, 1, 0); exp_win(72, 1, 1, 0); exp_win(73, 2, 1, 0); exp_win(74, 3, 1, 1);
    for (int d = 71; d <= 78; d++) px(d, 1'b0);
    idle(2);
    chk("restart_q", 64'(exp_q.size()), 64'h0);
    chk("err_held", 64'(sof_err), 64'h1);
    chk("restart_fd", 64'(fd_cnt), 64'd3);

    // asynchronous reset mid-line
    px(1, 1'b1); px(2, 1'b0); px(3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_taps", 64'({tap1, tap2, tap3, tap4, tap5}), 64'h0);
    chk("arst_en", 64'(Enable), 64'h0);
    chk("arst_col", 64'(win_col), 64'h0);
    chk("arst_row", 64'(win_row), 64'h0);
    chk("arst_fd", 64'(frame_done), 64'h0);
    chk("arst_err", 64'(sof_err), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_win(20, 0, 0, 0);
    for (int d = 20; d <= 24; d++) px(d, d == 20);
    idle(3);
    chk("post_q", 64'(exp_q.size()), 64'h0);
    chk("post_en", 64'(en_cnt), 64'd27);
    chk("post_err", 64'(sof_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
